pipe_stage_buf: RTL and testbench

- Generic, parametrised inter-stage pipeline register used between IF/ID/EX/MEM/WB. It is the successor to the fixed per-stage struct registers.
- Carries an opaque payload of PAYLOAD_W bits, for example a packed id_ex_t, using a valid/ready handshake.
- Contains a 2-entry skid buffer, so in_ready is fully registered and back-pressure does not form a combinational path across stages.
- Supports a synchronous flush for branch/exception squash.

---
 rtl/pipe_stage_buf.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline register with 2-entry skid buffer and flush
// Optional statistics counters: define PIPE_STAGE_BUF_STATS_EN.
module pipe_stage_buf #(
    parameter int                   PAYLOAD_W = 96,
    parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 flush,
`ifdef PIPE_STAGE_BUF_STATS_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_count,
    output logic [31:0]          full_cycles,
`endif
    output logic [1:0]           occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             occ_q, occ_d;
    logic                   accept;
    logic                   emit;

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid holds the younger entry; it becomes the head once main drains.
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        occ_d       = state_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic [31:0] full_cycles_q, full_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        full_cycles_d  = full_cycles_q;
        if (out_valid_q && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
        if ((state_q == FULL) && (full_cycles_q != 32'hFFFF_FFFF)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
            full_cycles_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            full_cycles_q  <= full_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign full_cycles  = full_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

    localparam int PW = 96;

    logic          clk;
    logic          nrst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          flush;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   flush_count;
    logic [31:0]   full_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_buf #(.PAYLOAD_W(PW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
`ifdef PIPE_STAGE_BUF_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .full_cycles  (full_cycles),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #12;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        do_reset();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occ", occupancy, 0);
        check("rst_out_data", out_data, 0);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 1'b1, 1'b0);
            step();
            check("stream_data", out_data, i);
            check("stream_valid", out_valid, 1);
            check("stream_in_ready", in_ready, 1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("stream_drain_occ", occupancy, 0);
        check("stream_drain_valid", out_valid, 0);

        // Back-pressure fill, refused third offer, then drain in order
        drive(1'b1, 'hA, 1'b0, 1'b0);
        step();
        check("bp_occ1", occupancy, 1);
        check("bp_rdy1", in_ready, 1);
        drive(1'b1, 'hB, 1'b0, 1'b0);
        step();
        check("bp_occ2", occupancy, 2);
        check("bp_rdy2", in_ready, 0);
        check("bp_head_a", out_data, 'hA);
        drive(1'b1, 'hC, 1'b0, 1'b0);
        step();
        check("bp_refuse_occ", occupancy, 2);
        check("bp_refuse_head", out_data, 'hA);
        drive(1'b1, 'hC, 1'b1, 1'b0);
        step();
        check("bp_out_b", out_data, 'hB);
        check("bp_occ_after_a", occupancy, 1);
        check("bp_rdy_after_a", in_ready, 1);
        step();
        check("bp_out_c", out_data, 'hC);
        check("bp_occ_c", occupancy, 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("bp_empty_occ", occupancy, 0);
        check("bp_empty_valid", out_valid, 0);

        // Stall stability
        drive(1'b1, 'h55, 1'b0, 1'b0);
        step();
        drive(1'b0, 'h77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_data", out_data, 'h55);
            check("stall_valid", out_valid, 1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("stall_release_occ", occupancy, 0);

        // Flush while FULL with a concurrent offer
        drive(1'b1, 'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 'hB, 1'b0, 1'b0);
        step();
        check("fl_pre_occ", occupancy, 2);
        drive(1'b1, 'hC, 1'b0, 1'b1);
        step();
        check("fl_occ", occupancy, 0);
        check("fl_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_data", out_data, 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_c", out_valid, 0);
        end

        // Flush from ONE with a concurrent accept: accept is dropped
        drive(1'b1, 'h11, 1'b1, 1'b0);
        step();
        drive(1'b1, 'h22, 1'b1, 1'b1);
        step();
        check("fl1_occ", occupancy, 0);
        check("fl1_valid", out_valid, 0);
        drive(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_BUF_STATS_EN
        do_reset();
        check("st_rst_stall", stall_cycles, 0);
        drive(1'b1, 'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 'hB, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        check("st_stall", stall_cycles, 3);
        check("st_full", full_cycles, 2);
        check("st_flush", flush_count, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
